pe_array_ctrl: RTL
==================

PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYC, default 10: idle cycles (pe_en=0) between last feed and first result read.
REQ-002 SHALL have clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have wr_en  in  1  tile-buffer write strobe.
REQ-005 SHALL have wr_sel  in  1  0 = data tile A, 1 = weight tile B.
REQ-006 SHALL have wr_addr  in  4  element index, row*4+col.
REQ-007 SHALL have wr_data  in  8  element value.
REQ-008 SHALL have start  in  1  single-cycle tile-run request.
REQ-009 SHALL have busy  out  1  high from CLEAR through last result handshake.
REQ-010 SHALL have done  out  1  one-cycle pulse after last result accepted.
REQ-011 SHALL have pe_en  out  1  array input enable.
REQ-012 SHALL have pe_data  out  32  lane i in bits [8i+7:8i], to array data_in_i.
REQ-013 SHALL have pe_weight  out  32  lane j in bits [8j+7:8j], to array weight_in_j.
REQ-014 SHALL have pe_clr_n  out  1  active-low array accumulator clear, ANDed with rst_n at integration.
REQ-015 SHALL have pe_out_sel  out  4  array result select.
REQ-016 SHALL have pe_result  in  32  array result for pe_out_sel (combinational in array).
REQ-017 SHALL have res_valid / res_ready  out / in  1 / 1  result stream handshake.
REQ-018 SHALL have res_data  out  32  result value; res_idx  out  4  PE index; res_last  out  1  marks index 15.

Function
REQ-019 SHALL hold two 16x8 register buffers A and B; wr_en writes buffer[wr_sel][wr_addr] only while in IDLE, ignored otherwise.
REQ-020 SHALL implement states IDLE, CLEAR, FEED, FLUSH, DRAIN.
REQ-021 IDLE->CLEAR SHALL occur on start=1 in IDLE; start outside IDLE SHALL be ignored.
REQ-022 A write and start in the same IDLE cycle SHALL both take effect; the run SHALL use the written value.
REQ-023 CLEAR SHALL last exactly 1 cycle with pe_clr_n=0; pe_clr_n SHALL be 1 in all other states.
REQ-024 FEED SHALL last 4 cycles, k=0..3: pe_en=1, pe_data lane i = A[i][k], pe_weight lane j = B[k][j]; no skew applied here (array skews internally).
REQ-025 Outside FEED pe_en SHALL be 0 and pe_data, pe_weight SHALL be 0.
REQ-026 FLUSH SHALL last exactly FLUSH_CYC cycles, then enter DRAIN with index 0.
REQ-027 In DRAIN: pe_out_sel=res_idx=index, res_valid=1, res_data=pe_result, res_last=(index==15).
REQ-028 Index SHALL advance only on res_valid&&res_ready; res_idx/res_data SHALL stay stable while stalled.
REQ-029 Handshake at index 15 SHALL go to IDLE, pulse done for that next cycle, drop busy.
REQ-030 Timing from start at cycle 0: CLEAR cycle 1, FEED cycles 2-5, FLUSH cycles 6..5+FLUSH_CYC, first res_valid at 6+FLUSH_CYC.
REQ-031 Width rules: no arithmetic in this block; values pass through unmodified (signedness owned by PE).

Reset
REQ-032 rst_n low SHALL force IDLE, clear A and B to 0, and drive busy=0, done=0, pe_en=0, pe_data=0, pe_weight=0, pe_clr_n=1, pe_out_sel=0, res_valid=0, res_idx=0, res_last=0.
REQ-033 Reset asserted in any state SHALL abort the run with no done pulse; first post-reset start SHALL run normally.

Verification
REQ-034 A=identity, B[r][c]=r*4+c, start -> 16 results, res_idx 0..15, res_data[n]=n, res_last only at 15, done once.
REQ-035 A,B all 127 -> every res_data = 64516; pe_en high exactly 4 cycles, cycles 2-5 after start.
REQ-036 res_ready low 3 cycles at index 5 -> res_idx 5 and res_data held, no index skipped or duplicated.
REQ-037 Two back-to-back runs, same tiles -> pe_clr_n low once per run, second run results equal first (no accumulation).
REQ-038 rst_n low during FEED cycle 3 -> all outputs at reset values, no done; writes then start -> correct results.
REQ-039 wr_en during busy with wr_data=0xFF -> buffer unchanged, next run results unaffected.

Source files
------------

// File: rtl/pe_array_ctrl.sv
// Tile sequencer for a 4x4 systolic PE array: holds the A/B operand tiles, feeds one
// column/row per cycle, waits out the array pipeline, then streams the 16 results.
module pe_array_ctrl #(
   parameter int FLUSH_CYC = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic        wr_sel,
   input  logic [3:0]  wr_addr,
   input  logic [7:0]  wr_data,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        pe_en,
   output logic [31:0] pe_data,
   output logic [31:0] pe_weight,
   output logic        pe_clr_n,
   output logic [3:0]  pe_out_sel,
   input  logic [31:0] pe_result,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic [3:0]  res_idx,
   output logic        res_last
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_FEED  = 3'd2;
   localparam logic [2:0] S_FLUSH = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;

   // One counter serves as feed step, flush timer and drain index.
   localparam int CW = (FLUSH_CYC > 16) ? $clog2(FLUSH_CYC) : 4;

   logic [2:0]    state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          done_reg, done_next;
   logic [7:0]    buf_a [16];
   logic [7:0]    buf_b [16];

   logic          in_idle, in_feed, in_drain;
   logic [1:0]    k;
   logic [3:0]    idx;

   assign in_idle  = (state_reg == S_IDLE);
   assign in_feed  = (state_reg == S_FEED);
   assign in_drain = (state_reg == S_DRAIN);
   assign k        = cnt_reg[1:0];
   assign idx      = cnt_reg[3:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < 16; n++) begin
            buf_a[n] <= 8'd0;
            buf_b[n] <= 8'd0;
         end
      end else if (wr_en && in_idle) begin
         if (wr_sel) buf_b[wr_addr] <= wr_data;
         else        buf_a[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      done_next  = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_CLEAR;
               cnt_next   = '0;
            end
         end
         S_CLEAR: begin
            state_next = S_FEED;
            cnt_next   = '0;
         end
         S_FEED: begin
            if (cnt_reg == CW'(3)) begin
               state_next = S_FLUSH;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         S_FLUSH: begin
            if (cnt_reg == CW'(FLUSH_CYC - 1)) begin
               state_next = S_DRAIN;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         S_DRAIN: begin
            if (res_ready) begin
               if (idx == 4'd15) begin
                  state_next = S_IDLE;
                  cnt_next   = '0;
                  done_next  = 1'b1;
               end else begin
                  cnt_next = cnt_reg + CW'(1);
               end
            end
         end
         default: begin
            state_next = S_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         done_reg  <= done_next;
      end
   end

   // Unskewed feed: lane i carries A[i][k], lane j carries B[k][j].
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign pe_data[8*gi +: 8]   = in_feed ? buf_a[{2'(gi), k}] : 8'd0;
         assign pe_weight[8*gi +: 8] = in_feed ? buf_b[{k, 2'(gi)}] : 8'd0;
      end
   endgenerate

   assign busy       = !in_idle;
   assign done       = done_reg;
   assign pe_en      = in_feed;
   assign pe_clr_n   = (state_reg != S_CLEAR);
   assign pe_out_sel = in_drain ? idx : 4'd0;
   assign res_valid  = in_drain;
   assign res_idx    = in_drain ? idx : 4'd0;
   assign res_data   = in_drain ? pe_result : 32'd0;
   assign res_last   = in_drain && (idx == 4'd15);

endmodule
